// File: rtl/ps2_host_if.sv
// Host-side handshake bundle for ps2_host: receive FIFO port, transmit request
// port and status pulses.
interface ps2_host_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_err;
  logic       rx_ovf;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_nack;
  logic       busy;

  modport master (
    input  rx_data, rx_valid, rx_err, rx_ovf, tx_ready, tx_done, tx_nack, busy,
    output rx_ready, tx_data, tx_valid
  );

  modport slave (
    output rx_data, rx_valid, rx_err, rx_ovf, tx_ready, tx_done, tx_nack, busy,
    input  rx_ready, tx_data, tx_valid
  );
endinterface

// File: rtl/ps2_host.sv
// PS/2 host controller: synchronised, glitch-filtered line sampling, frame receive
// into a first-word-fall-through FIFO, and host-to-device transmit with ACK check.
module ps2_host #(
  parameter int unsigned HOLD_CYCLES    = 10000,
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       rst,
  inout  wire        ps2_clk,
  inout  wire        ps2_data,
  ps2_host_if.slave  bus
);
  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [2:0] {StIdle, StRx, StTxHold, StTxData, StTxAck} state_e;

  state_e        state_q;
  logic [1:0]    clk_sync_q, dat_sync_q;
  logic          clk_filt_q, clk_filt_prev_q;
  logic [FW-1:0] filt_cnt_q;
  logic [3:0]    bit_cnt_q;
  logic [8:0]    rx_sh_q;
  logic [9:0]    tx_sh_q;
  logic [HW-1:0] hold_cnt_q;
  logic [TW-1:0] to_cnt_q;
  logic          drive_clk_q, drive_data_q;
  logic          rx_err_q, rx_ovf_q, tx_done_q, tx_nack_q;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  logic       fall, dat_s, start_edge, timeout, full, pop, push, rx_last, frame_ok;
  logic [9:0] rx_frame;

  assign ps2_clk  = drive_clk_q  ? 1'b0 : 1'bz;
  assign ps2_data = drive_data_q ? 1'b0 : 1'bz;

  // A level change on ps2_clk is accepted only after FILTER_LEN consecutive samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync_q      <= 2'b11;
      dat_sync_q      <= 2'b11;
      clk_filt_q      <= 1'b1;
      clk_filt_prev_q <= 1'b1;
      filt_cnt_q      <= '0;
    end else begin
      clk_sync_q      <= {clk_sync_q[0], ps2_clk};
      dat_sync_q      <= {dat_sync_q[0], ps2_data};
      clk_filt_prev_q <= clk_filt_q;
      if (clk_sync_q[1] == clk_filt_q) begin
        filt_cnt_q <= '0;
      end else if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
        clk_filt_q <= clk_sync_q[1];
        filt_cnt_q <= '0;
      end else begin
        filt_cnt_q <= filt_cnt_q + FW'(1);
      end
    end
  end

  assign fall       = clk_filt_prev_q & ~clk_filt_q;
  assign dat_s      = dat_sync_q[1];
  assign start_edge = (state_q == StIdle) & fall & ~dat_s;
  assign timeout    = (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));
  assign rx_frame   = {dat_s, rx_sh_q};
  assign rx_last    = (state_q == StRx) & fall & (bit_cnt_q == 4'd9);
  assign frame_ok   = rx_frame[9] & (^rx_frame[8:0]);
  assign full       = (count_q == CW'(FIFO_DEPTH));
  assign pop        = (count_q != '0) & bus.rx_ready;
  assign push       = rx_last & frame_ok & (~full | pop);

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rx_frame[7:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      rx_sh_q      <= '0;
      tx_sh_q      <= '0;
      hold_cnt_q   <= '0;
      to_cnt_q     <= '0;
      drive_clk_q  <= 1'b0;
      drive_data_q <= 1'b0;
      rx_err_q     <= 1'b0;
      rx_ovf_q     <= 1'b0;
      tx_done_q    <= 1'b0;
      tx_nack_q    <= 1'b0;
    end else begin
      rx_err_q  <= 1'b0;
      rx_ovf_q  <= 1'b0;
      tx_done_q <= 1'b0;
      tx_nack_q <= 1'b0;
      to_cnt_q  <= fall ? '0 : to_cnt_q + TW'(1);
      unique case (state_q)
        StIdle: begin
          if (start_edge) begin
            state_q   <= StRx;
            bit_cnt_q <= '0;
            to_cnt_q  <= '0;
          end else if (bus.tx_valid) begin
            tx_sh_q      <= {1'b1, ~^bus.tx_data, bus.tx_data};
            hold_cnt_q   <= '0;
            drive_clk_q  <= 1'b1;
            drive_data_q <= (HOLD_CYCLES == 1);
            state_q      <= StTxHold;
          end
        end
        StRx: begin
          if (fall) begin
            rx_sh_q   <= rx_frame[9:1];
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd9) begin
              state_q <= StIdle;
              if (!frame_ok)        rx_err_q <= 1'b1;
              else if (full && !pop) rx_ovf_q <= 1'b1;
            end
          end else if (timeout) begin
            state_q  <= StIdle;
            rx_err_q <= 1'b1;
          end
        end
        StTxHold: begin
          hold_cnt_q <= hold_cnt_q + HW'(1);
          // Start bit goes onto the line while the clock is still held low.
          if (hold_cnt_q == HW'(HOLD_CYCLES - 2)) drive_data_q <= 1'b1;
          if (hold_cnt_q == HW'(HOLD_CYCLES - 1)) begin
            drive_clk_q <= 1'b0;
            bit_cnt_q   <= '0;
            to_cnt_q    <= '0;
            state_q     <= StTxData;
          end
        end
        StTxData: begin
          if (fall) begin
            drive_data_q <= ~tx_sh_q[0];
            tx_sh_q      <= {1'b1, tx_sh_q[9:1]};
            bit_cnt_q    <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd9) state_q <= StTxAck;
          end else if (timeout) begin
            drive_data_q <= 1'b0;
            tx_nack_q    <= 1'b1;
            state_q      <= StIdle;
          end
        end
        StTxAck: begin
          if (fall) begin
            state_q <= StIdle;
            if (!dat_s) tx_done_q <= 1'b1;
            else        tx_nack_q <= 1'b1;
          end else if (timeout) begin
            drive_data_q <= 1'b0;
            tx_nack_q    <= 1'b1;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.rx_data  = (count_q != '0) ? mem_q[rd_ptr_q] : 8'h00;
  assign bus.rx_valid = (count_q != '0);
  assign bus.rx_err   = rx_err_q;
  assign bus.rx_ovf   = rx_ovf_q;
  assign bus.tx_done  = tx_done_q;
  assign bus.tx_nack  = tx_nack_q;
  assign bus.busy     = (state_q != StIdle);
  assign bus.tx_ready = rst & (state_q == StIdle) & ~start_edge;
endmodule

// File: tb/tb_ps2_host.sv
// Bench for ps2_host: a PS/2 device model on open-drain lines, with a scoreboard
// monitor comparing FIFO pops and status pulses against queued expectations.
module tb_ps2_host;
  localparam int unsigned HOLD  = 20;
  localparam int unsigned FILT  = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TO    = 400;
  localparam int unsigned HALF  = 15;

  typedef enum {EvErr, EvOvf, EvDone, EvNack} ev_e;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;
  wire  ps2_clk, ps2_data;

  pullup (ps2_clk);
  pullup (ps2_data);
  assign ps2_clk  = dev_clk_low  ? 1'b0 : 1'bz;
  assign ps2_data = dev_data_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  ps2_host_if bus ();

  ps2_host #(
    .HOLD_CYCLES    (HOLD),
    .FILTER_LEN     (FILT),
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .bus      (bus)
  );

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_rx[$];
  ev_e        exp_ev[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic sb_rx();
    logic [7:0] e;
    if (exp_rx.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL rx_pop: got byte %02h, expected no byte", bus.rx_data);
    end else begin
      e = exp_rx.pop_front();
      check("rx_data", {24'h0, bus.rx_data}, {24'h0, e});
    end
  endtask

  task automatic sb_ev(input ev_e k);
    ev_e e;
    tests++;
    if (exp_ev.size() == 0) begin
      fails++;
      $display("FAIL pulse: got %s, expected no pulse", k.name());
    end else begin
      e = exp_ev.pop_front();
      if (e != k) begin
        fails++;
        $display("FAIL pulse: got %s, expected %s", k.name(), e.name());
      end
    end
  endtask

  // Monitor: every presented output is matched against the scoreboard queues.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.rx_valid && bus.rx_ready) sb_rx();
      if (bus.rx_err)  sb_ev(EvErr);
      if (bus.rx_ovf)  sb_ev(EvOvf);
      if (bus.tx_done) sb_ev(EvDone);
      if (bus.tx_nack) sb_ev(EvNack);
    end
  end

  task automatic dev_bit(input logic b);
    dev_data_low = ~b;
    repeat (HALF) @(posedge clk);
    dev_clk_low = 1'b1;
    repeat (HALF) @(posedge clk);
    dev_clk_low = 1'b0;
  endtask

  task automatic dev_send(input logic [7:0] d, input logic flip_par);
    dev_bit(1'b0);
    for (int i = 0; i < 8; i++) dev_bit(d[i]);
    dev_bit(~^d ^ flip_par);
    dev_bit(1'b1);
    dev_data_low = 1'b0;
    repeat (40) @(posedge clk);
  endtask

  task automatic host_tx(input logic [7:0] d);
    int n;
    @(negedge clk);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    n = 0;
    while (!bus.tx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("tx_accept", {31'h0, bus.tx_ready}, 32'h1);
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  // Device side of a host transmit: measure hold, clock out 10 bits, optional ACK.
  task automatic dev_recv(input logic ack, output logic [9:0] bits, output int low,
                          output logic start_ok);
    int n;
    bits = '0;
    low = 0;
    start_ok = 1'b0;
    n = 0;
    while (ps2_clk !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      tests++;
      fails++;
      $display("FAIL tx_hold: ps2_clk never pulled low, expected hold");
      return;
    end
    while (ps2_clk === 1'b0 && low < int'(HOLD * 4)) begin
      low++;
      @(negedge clk);
    end
    start_ok = (ps2_data === 1'b0);
    for (int i = 0; i < 10; i++) begin
      repeat (HALF) @(posedge clk);
      dev_clk_low = 1'b1;
      repeat (HALF) @(posedge clk);
      bits[i] = ps2_data;
      dev_clk_low = 1'b0;
    end
    dev_data_low = ack;
    repeat (HALF) @(posedge clk);
    dev_clk_low = 1'b1;
    repeat (HALF) @(posedge clk);
    dev_clk_low = 1'b0;
    dev_data_low = 1'b0;
    repeat (40) @(posedge clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] bits;
    int         low;
    logic       st;
    bus.rx_ready = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_rx_valid", {31'h0, bus.rx_valid}, 32'h0);
    check("rst_rx_data", {24'h0, bus.rx_data}, 32'h0);
    check("rst_tx_ready", {31'h0, bus.tx_ready}, 32'h0);
    check("rst_busy", {31'h0, bus.busy}, 32'h0);
    check("rst_lines", {30'h0, ps2_clk, ps2_data}, 32'h3);
    rst = 1'b1;
    @(negedge clk);
    check("idle_tx_ready", {31'h0, bus.tx_ready}, 32'h1);
    bus.rx_ready = 1'b1;

    // Clean byte, then a parity error.
    exp_rx.push_back(8'hF4);
    dev_send(8'hF4, 1'b0);
    check("rx_f4_drained", {31'h0, bus.rx_valid}, 32'h0);
    exp_ev.push_back(EvErr);
    dev_send(8'hAA, 1'b1);
    check("rx_aa_no_valid", {31'h0, bus.rx_valid}, 32'h0);

    // Overflow: 5 bytes into a 4-deep FIFO with no pops.
    @(negedge clk);
    bus.rx_ready = 1'b0;
    exp_rx.push_back(8'h11);
    exp_rx.push_back(8'h22);
    exp_rx.push_back(8'h33);
    exp_rx.push_back(8'h44);
    exp_ev.push_back(EvOvf);
    dev_send(8'h11, 1'b0);
    dev_send(8'h22, 1'b0);
    dev_send(8'h33, 1'b0);
    dev_send(8'h44, 1'b0);
    dev_send(8'h55, 1'b0);
    @(negedge clk);
    check("ovf_head", {23'h0, bus.rx_valid, bus.rx_data}, {23'h0, 1'b1, 8'h11});
    bus.rx_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("ovf_drained", {31'h0, bus.rx_valid}, 32'h0);

    // Transmit 0xFF with ACK, then 0x07 with ACK and with no ACK.
    exp_ev.push_back(EvDone);
    host_tx(8'hFF);
    dev_recv(1'b1, bits, low, st);
    check("tx_ff_hold", low, HOLD);
    check("tx_ff_start", {31'h0, st}, 32'h1);
    check("tx_ff_bits", {22'h0, bits}, 32'h3FF);
    exp_ev.push_back(EvDone);
    host_tx(8'h07);
    dev_recv(1'b1, bits, low, st);
    check("tx_07_bits", {22'h0, bits}, 32'h207);
    exp_ev.push_back(EvNack);
    host_tx(8'h07);
    dev_recv(1'b0, bits, low, st);
    check("tx_nack_bits", {22'h0, bits}, 32'h207);
    check("tx_idle_after", {31'h0, bus.busy}, 32'h0);

    // Device clock stops mid-frame.
    exp_ev.push_back(EvErr);
    dev_bit(1'b0);
    dev_bit(1'b1);
    dev_bit(1'b0);
    dev_bit(1'b1);
    dev_data_low = 1'b0;
    repeat (TO - 30) @(negedge clk);
    check("to_still_busy", {31'h0, bus.busy}, 32'h1);
    repeat (60) @(negedge clk);
    check("to_released", {31'h0, bus.busy}, 32'h0);

    // Reset after the 4th edge, then a clean frame.
    dev_bit(1'b0);
    dev_bit(1'b1);
    dev_bit(1'b1);
    dev_bit(1'b0);
    dev_data_low = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", {31'h0, bus.busy}, 32'h0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    exp_rx.push_back(8'h55);
    dev_send(8'h55, 1'b0);

    repeat (20) @(negedge clk);
    check("rx_left", exp_rx.size(), 32'h0);
    check("ev_left", exp_ev.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
